// File: rtl/float_to_int_seq.sv
// Multi-cycle IEEE-754 single to signed int32 converter, shifting SHIFT_PER_CYCLE bits per cycle.
// Optional round-to-nearest-even when FTOI_ROUND_NEAREST_EN is defined; truncation toward zero otherwise.
module float_to_int_seq #(
    parameter int unsigned SHIFT_PER_CYCLE = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_float,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_int,
    output logic        out_invalid,
    output logic        out_inexact
);

    localparam int unsigned DATA_W = 32;
    localparam int unsigned EXP_W  = 8;
    localparam int unsigned FRAC_W = 23;
    localparam int unsigned CNT_W  = 5;

    localparam logic [EXP_W-1:0]  EXP_MAX  = 8'd255;
    localparam logic [EXP_W-1:0]  EXP_OVF  = 8'd158;
    localparam logic [EXP_W-1:0]  EXP_UNIT = 8'd150;
`ifdef FTOI_ROUND_NEAREST_EN
    localparam logic [EXP_W-1:0]  EXP_MIN  = 8'd126;
`else
    localparam logic [EXP_W-1:0]  EXP_MIN  = 8'd127;
`endif
    localparam logic [DATA_W-1:0] INT_MIN  = 32'h8000_0000;
    localparam logic [DATA_W-1:0] INT_MAX  = 32'h7FFF_FFFF;
    localparam logic [DATA_W-1:0] NEG_2_31 = 32'hCF00_0000;
    localparam logic [CNT_W-1:0]  STEP_MAX = CNT_W'(SHIFT_PER_CYCLE);

    typedef enum logic [2:0] {
        S_IDLE,
        S_UNPACK,
        S_SHIFT,
        S_FIX,
        S_DONE
    } state_t;

    state_t             r_state;
    logic [DATA_W-1:0]  r_float;
    logic [DATA_W-1:0]  r_mag;
    logic [CNT_W-1:0]   r_cnt;
    logic               r_left;
    logic               r_guard;
    logic               r_sticky;
    logic               r_in_ready;
    logic               r_out_valid;
    logic [DATA_W-1:0]  r_out_int;
    logic               r_out_invalid;
    logic               r_out_inexact;

    state_t             w_state_nxt;
    logic [DATA_W-1:0]  w_float_nxt;
    logic [DATA_W-1:0]  w_mag_nxt;
    logic [CNT_W-1:0]   w_cnt_nxt;
    logic               w_left_nxt;
    logic               w_guard_nxt;
    logic               w_sticky_nxt;
    logic               w_out_valid_nxt;
    logic [DATA_W-1:0]  w_out_int_nxt;
    logic               w_out_invalid_nxt;
    logic               w_out_inexact_nxt;

    logic               w_sign;
    logic [EXP_W-1:0]   w_exp;
    logic [FRAC_W-1:0]  w_frac;
    logic [CNT_W-1:0]   w_step;
    logic [DATA_W-1:0]  w_sh_mag;
    logic               w_sh_guard;
    logic               w_sh_sticky;
    logic               w_round;
    logic [DATA_W-1:0]  w_mag_rnd;

    assign w_sign    = r_float[31];
    assign w_exp     = r_float[30:23];
    assign w_frac    = r_float[22:0];
    assign w_step    = (r_cnt < STEP_MAX) ? r_cnt : STEP_MAX;
    assign w_mag_rnd = r_mag + DATA_W'(w_round);

`ifdef FTOI_ROUND_NEAREST_EN
    assign w_round = r_guard & (r_sticky | r_mag[0]);
`else
    assign w_round = 1'b0;
`endif

    // One SHIFT cycle: up to SHIFT_PER_CYCLE single-bit steps, tracking bits lost to the right
    always_comb begin
        w_sh_mag    = r_mag;
        w_sh_guard  = r_guard;
        w_sh_sticky = r_sticky;
        for (int unsigned i = 0; i < SHIFT_PER_CYCLE; i++) begin
            if (CNT_W'(i) < w_step) begin
                if (r_left) begin
                    w_sh_mag = {w_sh_mag[DATA_W-2:0], 1'b0};
                end else begin
`ifdef FTOI_ROUND_NEAREST_EN
                    w_sh_sticky = w_sh_sticky | w_sh_guard;
                    w_sh_guard  = w_sh_mag[0];
`else
                    w_sh_sticky = w_sh_sticky | w_sh_mag[0];
`endif
                    w_sh_mag = {1'b0, w_sh_mag[DATA_W-1:1]};
                end
            end
        end
    end

    // Next-state and next-output logic
    always_comb begin
        w_state_nxt       = r_state;
        w_float_nxt       = r_float;
        w_mag_nxt         = r_mag;
        w_cnt_nxt         = r_cnt;
        w_left_nxt        = r_left;
        w_guard_nxt       = r_guard;
        w_sticky_nxt      = r_sticky;
        w_out_valid_nxt   = r_out_valid;
        w_out_int_nxt     = r_out_int;
        w_out_invalid_nxt = r_out_invalid;
        w_out_inexact_nxt = r_out_inexact;

        case (r_state)
            S_IDLE: begin
                if (in_valid) begin
                    w_float_nxt = in_float;
                    w_state_nxt = S_UNPACK;
                end
            end
            S_UNPACK: begin
                w_mag_nxt    = {8'b0, 1'b1, w_frac};
                w_guard_nxt  = 1'b0;
                w_sticky_nxt = 1'b0;
                w_left_nxt   = 1'b0;
                w_cnt_nxt    = '0;
                if (w_exp == EXP_MAX) begin
                    w_state_nxt       = S_DONE;
                    w_out_valid_nxt   = 1'b1;
                    w_out_int_nxt     = (w_frac != '0 || w_sign) ? INT_MIN : INT_MAX;
                    w_out_invalid_nxt = 1'b1;
                    w_out_inexact_nxt = 1'b0;
                end else if (w_exp >= EXP_OVF) begin
                    w_state_nxt       = S_DONE;
                    w_out_valid_nxt   = 1'b1;
                    w_out_inexact_nxt = 1'b0;
                    // -2^31 is the only exactly representable value at this magnitude
                    if (r_float == NEG_2_31) begin
                        w_out_int_nxt     = INT_MIN;
                        w_out_invalid_nxt = 1'b0;
                    end else begin
                        w_out_int_nxt     = w_sign ? INT_MIN : INT_MAX;
                        w_out_invalid_nxt = 1'b1;
                    end
                end else if (w_exp < EXP_MIN) begin
                    w_state_nxt       = S_DONE;
                    w_out_valid_nxt   = 1'b1;
                    w_out_int_nxt     = '0;
                    w_out_invalid_nxt = 1'b0;
                    w_out_inexact_nxt = |r_float[30:0];
                end else if (w_exp >= EXP_UNIT) begin
                    w_left_nxt  = 1'b1;
                    w_cnt_nxt   = CNT_W'(w_exp - EXP_UNIT);
                    w_state_nxt = (w_exp == EXP_UNIT) ? S_FIX : S_SHIFT;
                end else begin
                    w_cnt_nxt   = CNT_W'(EXP_UNIT - w_exp);
                    w_state_nxt = S_SHIFT;
                end
            end
            S_SHIFT: begin
                w_mag_nxt    = w_sh_mag;
                w_guard_nxt  = w_sh_guard;
                w_sticky_nxt = w_sh_sticky;
                w_cnt_nxt    = r_cnt - w_step;
                if (r_cnt == w_step) begin
                    w_state_nxt = S_FIX;
                end
            end
            S_FIX: begin
                w_state_nxt       = S_DONE;
                w_out_valid_nxt   = 1'b1;
                w_out_inexact_nxt = r_guard | r_sticky;
                if (!w_sign && w_mag_rnd[DATA_W-1]) begin
                    w_out_int_nxt     = INT_MAX;
                    w_out_invalid_nxt = 1'b1;
                end else begin
                    w_out_int_nxt     = w_sign ? (DATA_W'(0) - w_mag_rnd) : w_mag_rnd;
                    w_out_invalid_nxt = 1'b0;
                end
            end
            S_DONE: begin
                if (out_ready) begin
                    w_state_nxt     = S_IDLE;
                    w_out_valid_nxt = 1'b0;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state       <= S_IDLE;
            r_float       <= '0;
            r_mag         <= '0;
            r_cnt         <= '0;
            r_left        <= 1'b0;
            r_guard       <= 1'b0;
            r_sticky      <= 1'b0;
            r_in_ready    <= 1'b1;
            r_out_valid   <= 1'b0;
            r_out_int     <= '0;
            r_out_invalid <= 1'b0;
            r_out_inexact <= 1'b0;
        end else begin
            r_state       <= w_state_nxt;
            r_float       <= w_float_nxt;
            r_mag         <= w_mag_nxt;
            r_cnt         <= w_cnt_nxt;
            r_left        <= w_left_nxt;
            r_guard       <= w_guard_nxt;
            r_sticky      <= w_sticky_nxt;
            r_in_ready    <= (w_state_nxt == S_IDLE);
            r_out_valid   <= w_out_valid_nxt;
            r_out_int     <= w_out_int_nxt;
            r_out_invalid <= w_out_invalid_nxt;
            r_out_inexact <= w_out_inexact_nxt;
        end
    end

    assign in_ready    = r_in_ready;
    assign out_valid   = r_out_valid;
    assign out_int     = r_out_int;
    assign out_invalid = r_out_invalid;
    assign out_inexact = r_out_inexact;

endmodule

// File: tb/tb_float_to_int_seq.sv
// Scoreboard bench for float_to_int_seq: two instances (1 and 8 bits per shift cycle) share stimulus,
// expectations come from an arithmetic reference model.
`timescale 1ns/1ps
module tb_float_to_int_seq;

`ifdef FTOI_ROUND_NEAREST_EN
    localparam int MIN_E = -1;
`else
    localparam int MIN_E = 0;
`endif

    typedef struct packed {
        logic [31:0] val;
        logic        inv;
        logic        inx;
        logic [31:0] lat;
        logic [31:0] acc;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic [31:0] in_float;
    logic        out_ready = 1'b0;
    logic        o_rdy [2];
    logic        o_vld [2];
    logic [31:0] o_int [2];
    logic        o_inv [2];
    logic        o_inx [2];

    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    int   rdy_mode = 0;
    exp_t q0[$];
    exp_t q1[$];
    logic prev_v [2] = '{1'b0, 1'b0};
    int   rise_cyc [2] = '{0, 0};

    float_to_int_seq #(.SHIFT_PER_CYCLE(1)) dut1 (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(o_rdy[0]), .in_float(in_float),
        .out_valid(o_vld[0]), .out_ready(out_ready), .out_int(o_int[0]),
        .out_invalid(o_inv[0]), .out_inexact(o_inx[0]));

    float_to_int_seq #(.SHIFT_PER_CYCLE(8)) dut8 (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(o_rdy[1]), .in_float(in_float),
        .out_valid(o_vld[1]), .out_ready(out_ready), .out_int(o_int[1]),
        .out_invalid(o_inv[1]), .out_inexact(o_inx[1]));

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk) begin
        #1;
        case (rdy_mode)
            0:       out_ready = ($urandom_range(0, 3) != 0);
            1:       out_ready = 1'b0;
            default: out_ready = 1'b1;
        endcase
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    // Reference: value = 1.frac * 2^e, evaluated with integer quotient/remainder
    function automatic exp_t model(input logic [31:0] f, input int s);
        exp_t   r;
        int     e;
        int     cnt;
        longint m;
        longint q;
        longint rem;
        longint half;
        logic   sgn;
        r    = '0;
        sgn  = f[31];
        e    = int'(f[30:23]) - 127;
        m    = longint'({1'b1, f[22:0]});
        r.lat = 32'd2;
        if (f[30:23] == 8'hFF) begin
            r.val = (f[22:0] != 0 || sgn) ? 32'h8000_0000 : 32'h7FFF_FFFF;
            r.inv = 1'b1;
        end else if (f == 32'hCF00_0000) begin
            r.val = 32'h8000_0000;
        end else if (e >= 31) begin
            r.val = sgn ? 32'h8000_0000 : 32'h7FFF_FFFF;
            r.inv = 1'b1;
        end else if (e < MIN_E) begin
            r.val = 32'h0;
            r.inx = (f[30:0] != 0);
        end else begin
            if (e >= 23) begin
                cnt  = e - 23;
                q    = m << cnt;
                rem  = 0;
                half = 0;
            end else begin
                cnt  = 23 - e;
                q    = m >> cnt;
                rem  = m - (q << cnt);
                half = longint'(1) << (cnt - 1);
            end
            r.lat = 32'((cnt + s - 1) / s + 3);
            r.inx = (rem != 0);
`ifdef FTOI_ROUND_NEAREST_EN
            if (rem > half || (rem == half && rem != 0 && q[0])) q = q + 1;
`endif
            if (!sgn && q >= (longint'(1) << 31)) begin
                r.val = 32'h7FFF_FFFF;
                r.inv = 1'b1;
            end else begin
                r.val = sgn ? 32'(-q) : 32'(q);
            end
        end
        return r;
    endfunction

    task automatic send(input logic [31:0] f, input bit track);
        int   n;
        exp_t e;
        n = 0;
        while (!(o_rdy[0] && o_rdy[1])) begin
            @(posedge clk); #1;
            n++;
            if (n > 1000) begin
                checks++; errors++;
                $display("FAIL send_timeout actual=busy required=ready");
                return;
            end
        end
        in_float = f;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        in_float = $urandom;
        if (track) begin
            e = model(f, 1); e.acc = 32'(cyc); q0.push_back(e);
            e = model(f, 8); e.acc = 32'(cyc); q1.push_back(e);
        end
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (q0.size() != 0 || q1.size() != 0 || !(o_rdy[0] && o_rdy[1])) begin
            @(posedge clk); #1;
            n++;
            if (n > 3000) begin
                checks++; errors++;
                $display("FAIL drain_timeout actual=%0d/%0d pending required=0", q0.size(), q1.size());
                q0.delete(); q1.delete();
                return;
            end
        end
    endtask

    // Monitor: pops one expectation per accepted output of each instance
    always @(negedge clk) begin
        exp_t e;
        bit   have;
        for (int k = 0; k < 2; k++) begin
            if (o_vld[k] && !prev_v[k]) rise_cyc[k] = cyc;
            if (o_vld[k] && out_ready) begin
                have = 1'b0;
                if (k == 0 && q0.size() > 0) begin e = q0.pop_front(); have = 1'b1; end
                if (k == 1 && q1.size() > 0) begin e = q1.pop_front(); have = 1'b1; end
                if (!have) begin
                    checks++; errors++;
                    $display("FAIL unexpected_out dut=%0d actual=%h required=none", k, o_int[k]);
                end else begin
                    chk(k == 0 ? "s1_int" : "s8_int", o_int[k], e.val);
                    chk(k == 0 ? "s1_invalid" : "s8_invalid", 32'(o_inv[k]), 32'(e.inv));
                    chk(k == 0 ? "s1_inexact" : "s8_inexact", 32'(o_inx[k]), 32'(e.inx));
                    chk(k == 0 ? "s1_latency" : "s8_latency", 32'(rise_cyc[k]) - e.acc + 32'd1, e.lat);
                end
            end
            prev_v[k] = o_vld[k];
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] directed [18];
        int          n;
        directed = '{32'h4244_0000, 32'hC0E0_0000, 32'h3FC0_0000, 32'h4020_0000, 32'h3F00_0000,
                     32'h4F00_0000, 32'hCF00_0000, 32'h7FC0_0000, 32'hFF80_0000, 32'h7F80_0000,
                     32'h0000_0000, 32'h8000_0000, 32'h4EFF_FFFF, 32'hCEFF_FFFF, 32'h3F7F_FFFF,
                     32'hBFC0_0000, 32'h3F40_0000, 32'h0000_0001};
        reset    = 1'b1;
        in_valid = 1'b0;
        in_float = 32'h0;
        #1;
        for (int k = 0; k < 2; k++) begin
            chk("reset_in_ready", 32'(o_rdy[k]), 32'd1);
            chk("reset_out_valid", 32'(o_vld[k]), 32'd0);
            chk("reset_out_int", o_int[k], 32'h0);
            chk("reset_flags", {30'b0, o_inv[k], o_inx[k]}, 32'h0);
        end
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;

        foreach (directed[i]) send(directed[i], 1'b1);
        for (int i = 0; i < 150; i++) begin
            logic [31:0] f;
            f = $urandom;
            if (i % 4 != 0) f[30:23] = 8'($urandom_range(120, 160));
            send(f, 1'b1);
        end
        drain();

        // Hold a result in DONE and poke in_valid while stalled
        rdy_mode = 1;
        @(posedge clk); #1;
        send(32'h4244_0000, 1'b1);
        n = 0;
        while (!(o_vld[0] && o_vld[1]) && n < 100) begin @(negedge clk); n++; end
        for (int k = 0; k < 10; k++) begin
            @(posedge clk); #1;
            in_valid = k[0];
            in_float = $urandom;
            @(negedge clk);
            for (int d = 0; d < 2; d++) begin
                chk("stall_valid", 32'(o_vld[d]), 32'd1);
                chk("stall_int", o_int[d], 32'h31);
                chk("stall_in_ready", 32'(o_rdy[d]), 32'd0);
            end
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
        rdy_mode = 2;
        n = 0;
        do begin @(negedge clk); n++; end while (!out_ready && n < 10);
        @(posedge clk); #1;
        for (int d = 0; d < 2; d++) begin
            chk("release_in_ready", 32'(o_rdy[d]), 32'd1);
            chk("release_valid", 32'(o_vld[d]), 32'd0);
        end
        rdy_mode = 0;
        drain();

        // Abort a conversion mid-shift with reset
        send(32'h4244_0000, 1'b0);
        repeat (3) @(posedge clk);
        #1 reset = 1'b1;
        #1;
        for (int d = 0; d < 2; d++) begin
            chk("abort_valid", 32'(o_vld[d]), 32'd0);
            chk("abort_in_ready", 32'(o_rdy[d]), 32'd1);
        end
        @(posedge clk); #1 reset = 1'b0;
        send(32'h4B00_0001, 1'b1);
        send(32'h4244_0000, 1'b1);
        drain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
